// File: rtl/sumador_serie_param_pkg.sv
// Shared types for the digit-serial adder: FSM state encoding.
package sumador_serie_param_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

endpackage

// File: rtl/sumador_digito.sv
// Combinational DIGIT-bit ripple-carry adder slice; also exposes the carry into its top bit.
module sumador_digito #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             ctop
);

  always_comb begin
    logic carry;
    carry = cin;
    s     = '0;
    ctop  = cin;
    for (int i = 0; i < int'(DIGIT); i++) begin
      if (i == int'(DIGIT) - 1) ctop = carry;
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
    end
    cout = carry;
  end

endmodule

// File: rtl/sumador_serie_param.sv
// Digit-serial adder: WIDTH-bit a+b+cin computed DIGIT bits per clock with start/busy/done.
module sumador_serie_param
  import sumador_serie_param_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned STEPS = WIDTH / DIGIT;
  localparam int unsigned CntW  = $clog2(STEPS + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(STEPS - 1);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("sumador_serie_param: DIGIT must divide WIDTH exactly");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, done_q, done_d;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout, dig_ctop;

  sumador_digito #(
    .DIGIT(DIGIT)
  ) u_digito (
    .a    (a_q[DIGIT-1:0]),
    .b    (b_q[DIGIT-1:0]),
    .cin  (carry_q),
    .s    (dig_sum),
    .cout (dig_cout),
    .ctop (dig_ctop)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        // New digit enters at the MSB; after STEPS shifts the LSB digit sits at bit 0.
        acc_d   = WIDTH'({dig_sum, acc_q} >> DIGIT);
        carry_d = dig_cout;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StIdle;
          sum_d   = acc_d;
          cout_d  = dig_cout;
          ovf_d   = dig_ctop ^ dig_cout;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == StRun);
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_sumador_serie_param.sv
// Bench for sumador_serie_param: four instances (DIGIT 1,2,4,8) at WIDTH 8.
module tb_sumador_serie_param;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] start;
  logic [7:0] a, b;
  logic       cin;
  logic [3:0] busy, done, cout, ovf;
  logic [7:0] sum [4];
  logic [7:0] prev_sum [4];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sumador_serie_param #(
      .WIDTH(8),
      .DIGIT(1 << g)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start[g]),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .busy     (busy[g]),
      .done     (done[g]),
      .sum      (sum[g]),
      .cout     (cout[g]),
      .overflow (ovf[g])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation on instance d, checking handshake, latency and results.
  task automatic run_op(input int d, input logic [7:0] ta, input logic [7:0] tb_op,
                        input logic tc, input logic [7:0] es, input logic ec, input logic eo,
                        input string tag);
    int n;
    int steps;
    steps = 8 >> d;
    @(negedge clk);
    a = ta; b = tb_op; cin = tc; start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    n = 1;
    if (steps > 1) begin
      check_eq({tag, " busy"}, 32'(busy[d]), 32'd1);
      check_eq({tag, " hold"}, 32'(sum[d]), 32'(prev_sum[d]));
    end
    n = 0;
    while (!done[d] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, " latency"}, 32'(n), 32'(steps));
    check_eq({tag, " sum"}, 32'(sum[d]), 32'(es));
    check_eq({tag, " cout"}, 32'(cout[d]), 32'(ec));
    check_eq({tag, " ovf"}, 32'(ovf[d]), 32'(eo));
    check_eq({tag, " idle"}, 32'(busy[d]), 32'd0);
    prev_sum[d] = es;
    @(posedge clk); #1;
    check_eq({tag, " done drop"}, 32'(done[d]), 32'd0);
  endtask

  initial begin
    int ndone;
    int e;
    int edges [3];
    logic [8:0] full;
    logic [7:0] ra, rb;
    logic       rc;

    rst = 1'b1; start = '0; a = '0; b = '0; cin = 1'b0;
    for (int i = 0; i < 4; i++) prev_sum[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check_eq("reset busy", 32'(busy[i]), 32'd0);
      check_eq("reset done", 32'(done[i]), 32'd0);
      check_eq("reset sum", 32'(sum[i]), 32'd0);
      check_eq("reset cout/ovf", 32'({cout[i], ovf[i]}), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors on the DIGIT=2 instance.
    run_op(1, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, "d2 5a+3c");
    run_op(1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "d2 ff+01");
    run_op(1, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, "d2 cin");
    run_op(1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "d2 80+80");

    // start during RUN must be ignored.
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; cin = 1'b0; start[1] = 1'b1;
    @(posedge clk); #1;
    start[1] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    a = 8'h11; b = 8'h11; start[1] = 1'b1;
    @(posedge clk); #1;
    start[1] = 1'b0; a = 8'h00; b = 8'h00;
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done[1]) ndone++;
    end
    check_eq("ignore done count", 32'(ndone), 32'd1);
    check_eq("ignore sum", 32'(sum[1]), 32'h96);
    check_eq("ignore ovf", 32'(ovf[1]), 32'd1);
    prev_sum[1] = 8'h96;

    // Reset on the third RUN edge aborts the operation.
    @(negedge clk);
    a = 8'hFF; b = 8'h01; start[1] = 1'b1;
    @(posedge clk); #1;
    start[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("abort busy", 32'(busy[1]), 32'd0);
    check_eq("abort sum", 32'(sum[1]), 32'd0);
    check_eq("abort done", 32'(done[1]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done[1]) ndone++;
    end
    check_eq("abort no done", 32'(ndone), 32'd0);
    prev_sum[1] = 8'h00;
    run_op(1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "after abort");

    // Back-to-back with start held high: done after edges 5, 10, 15 (accept edge = 1).
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; cin = 1'b0; start[1] = 1'b1;
    ndone = 0;
    for (e = 1; e <= 15; e++) begin
      @(posedge clk); #1;
      if (done[1]) begin
        if (ndone < 3) edges[ndone] = e;
        ndone++;
      end
    end
    start[1] = 1'b0;
    check_eq("b2b count", 32'(ndone), 32'd3);
    check_eq("b2b edge0", 32'(edges[0]), 32'd5);
    check_eq("b2b edge1", 32'(edges[1]), 32'd10);
    check_eq("b2b edge2", 32'(edges[2]), 32'd15);
    check_eq("b2b sum", 32'(sum[1]), 32'h96);
    repeat (6) @(posedge clk);
    #1;
    prev_sum[1] = 8'h96;

    // Random sweep across all digit sizes.
    for (int d = 0; d < 4; d++) begin
      for (int t = 0; t < 200; t++) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        rc = 1'($urandom);
        full = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
        run_op(d, ra, rb, rc, full[7:0], full[8],
               (ra[7] == rb[7]) && (full[7] != ra[7]), $sformatf("rand d%0d", 1 << d));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
